// File: rtl/gpreg_pkg.sv
// Shared types and default sizes for the general-purpose register file.
package gpreg_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned NREG_DEF = 32;

  // INIT: zeroing sweep in progress; RUN: normal read/write/issue operation
  typedef enum logic {
    INIT,
    RUN
  } state_e;

endpackage

// File: rtl/gpreg_scoreboard.sv
// Busy-bit scoreboard: one pending-result bit per register with set, clear,
// clear-all and two combinational lookup ports. Entry 0 is never busy.
module gpreg_scoreboard
  import gpreg_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_all,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] lk_addr1,
  input  logic [AW-1:0] lk_addr2,
  output logic          lk_busy1,
  output logic          lk_busy2
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next busy vector: clears first, then set so that set wins on a collision
  always_comb begin
    busy_d = busy_q;
    if (clr_all) busy_d = '0;
    if (clr_en)  busy_d[clr_addr] = 1'b0;
    if (set_en)  busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy register, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Combinational lookups
  always_comb begin
    lk_busy1 = busy_q[lk_addr1];
    lk_busy2 = busy_q[lk_addr2];
  end

endmodule

// File: rtl/gp_regfile_sb.sv
// Register file with busy scoreboard and a post-reset zeroing sweep.
// Optional macro GPREG_BYPASS_EN: forwards same-cycle write data (and a
// cleared busy bit) to matching read ports.
module gp_regfile_sb
  import gpreg_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_req,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  input  logic            alu_src,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  output logic            busy1,
  output logic            busy2,
  output logic            ready
);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rf_q [NREG];

  logic            rf_we_d;
  logic [AW-1:0]   rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_d;

  logic            run;
  logic            wr_ok;
  logic            sb_clr_all, sb_set_en, sb_clr_en;
  logic [AW-1:0]   sb_clr_addr;
  logic            sb_busy1, sb_busy2;

  assign run   = (state_q == RUN);
  assign wr_ok = run && wr_en && (wr_addr != '0);
  assign ready = run;

  // Next-state and sweep counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (clr_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and sweep counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage write port: the sweep zeroes entry cnt, RUN takes the user write
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = cnt_q;
    rf_wdata_d = '0;
    if (!run) begin
      rf_we_d = 1'b1;
    end else if (wr_ok) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wr_addr;
      rf_wdata_d = wr_data;
    end
  end

  // Register storage; zeroed only by the sweep, so it carries no reset
  always_ff @(posedge clk) begin
    if (rf_we_d) rf_q[rf_waddr_d] <= rf_wdata_d;
  end

  // Scoreboard controls: the sweep clears one bit per cycle; a clear request
  // wipes all bits up front so no stale busy survives into the next RUN
  always_comb begin
    sb_clr_all  = run && clr_req;
    sb_set_en   = run && iss_en && (iss_addr != '0);
    sb_clr_en   = !run || wr_ok;
    sb_clr_addr = run ? wr_addr : cnt_q;
  end

  gpreg_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_all  (sb_clr_all),
    .set_en   (sb_set_en),
    .set_addr (iss_addr),
    .clr_en   (sb_clr_en),
    .clr_addr (sb_clr_addr),
    .lk_addr1 (rd_addr1),
    .lk_addr2 (rd_addr2),
    .lk_busy1 (sb_busy1),
    .lk_busy2 (sb_busy2)
  );

  // Combinational read ports; everything except imm reads as zero in INIT
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    busy1    = 1'b0;
    busy2    = 1'b0;
    if (run) begin
      if (rd_addr1 != '0) begin
        rd_data1 = rf_q[rd_addr1];
        busy1    = sb_busy1;
      end
      if (rd_addr2 != '0) begin
        rd_data2 = rf_q[rd_addr2];
        busy2    = sb_busy2;
      end
`ifdef GPREG_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr1)) begin
        rd_data1 = wr_data;
        busy1    = 1'b0;
      end
      if (wr_ok && (wr_addr == rd_addr2)) begin
        rd_data2 = wr_data;
        busy2    = 1'b0;
      end
`endif
    end
    if (alu_src) rd_data2 = imm;
  end

endmodule

// File: tb/tb_gp_regfile_sb.sv
// Self-checking bench for gp_regfile_sb (NREG=32, XLEN=64); honours
// GPREG_BYPASS_EN when defined.
module tb_gp_regfile_sb;

`ifdef GPREG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_req, wr_en, iss_en, alu_src;
  logic [4:0]  wr_addr, iss_addr, rd_addr1, rd_addr2;
  logic [63:0] wr_data, imm;
  logic [63:0] rd_data1, rd_data2;
  logic        busy1, busy2, ready;

  int checks = 0;
  int passes = 0;

  // Reference model: register values, busy bits, and how many sweep cycles remain
  logic [63:0] mreg [32];
  bit          mbusy [32];
  bit          m_run;
  int          m_left;

  gp_regfile_sb #(
    .XLEN (64),
    .NREG (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .alu_src  (alu_src),
    .imm      (imm),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .busy1    (busy1),
    .busy2    (busy2),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_rd(input logic [4:0] a, input bit port2);
    if (port2 && alu_src) return imm;
    if (!m_run || a == 5'd0) return 64'd0;
    if (BYP && wr_en && wr_addr == a) return wr_data;
    return mreg[a];
  endfunction

  function automatic bit exp_busy(input logic [4:0] a);
    if (!m_run || a == 5'd0) return 1'b0;
    if (BYP && wr_en && wr_addr == a) return 1'b0;
    return mbusy[a];
  endfunction

  task automatic idle();
    clr_req = 0; wr_en = 0; iss_en = 0; alu_src = 0;
    wr_addr = 0; iss_addr = 0; rd_addr1 = 0; rd_addr2 = 0;
    wr_data = 0; imm = 0;
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_left = 32;
    for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
  endtask

  // Advance one clock edge and apply the same edge to the model
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (m_run) begin
        if (wr_en && wr_addr != 0) begin
          mreg[wr_addr]  = wr_data;
          mbusy[wr_addr] = 1'b0;
        end
        if (iss_en && iss_addr != 0) mbusy[iss_addr] = 1'b1;
        if (clr_req) begin
          m_run  = 1'b0;
          m_left = 32;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_run = 1'b1;
          for (int i = 0; i < 32; i++) begin
            mreg[i]  = 64'd0;
            mbusy[i] = 1'b0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready); else passes++;
    checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) $display("FAIL reset_busy: got %b%b expected 00", busy1, busy2); else passes++;
    tick(); tick();
    rst_n = 1'b1;
    n = 0;
    while (ready === 1'b0 && n < 40) begin n++; tick(); end
    checks++; if (n != 32) $display("FAIL init_cycles: got %0d expected 32", n); else passes++;
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
      #2;
      checks++;
      if (rd_data1 !== 64'd0 || rd_data2 !== 64'd0)
        $display("FAIL init_zero x%0d: got %h/%h expected 0", i, rd_data1, rd_data2);
      else passes++;
      tick();
    end
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 1; wr_addr = 5; wr_data = 64'hDEAD_BEEF; rd_addr1 = 5;
    #2;
    checks++;
    if (rd_data1 !== (BYP ? 64'hDEAD_BEEF : 64'd0))
      $display("FAIL wr_same_cycle: got %h expected %h", rd_data1, BYP ? 64'hDEAD_BEEF : 64'd0);
    else passes++;
    tick();
    wr_en = 0;
    #2;
    checks++; if (rd_data1 !== 64'hDEAD_BEEF) $display("FAIL wr_next_cycle: got %h expected deadbeef", rd_data1); else passes++;
    tick();
  endtask

  task automatic test_x0();
    idle();
    wr_en = 1; wr_addr = 0; wr_data = 64'h1234; iss_en = 1; iss_addr = 0; rd_addr1 = 0;
    #2;
    checks++; if (rd_data1 !== 64'd0 || busy1 !== 1'b0) $display("FAIL x0_same: got %h busy %b expected 0/0", rd_data1, busy1); else passes++;
    tick();
    wr_en = 0; iss_en = 0;
    #2;
    checks++; if (rd_data1 !== 64'd0 || busy1 !== 1'b0) $display("FAIL x0_after: got %h busy %b expected 0/0", rd_data1, busy1); else passes++;
    tick();
  endtask

  task automatic test_busy();
    idle();
    rd_addr1 = 7; iss_en = 1; iss_addr = 7;
    #2;
    checks++; if (busy1 !== 1'b0) $display("FAIL busy_pre_issue: got %b expected 0", busy1); else passes++;
    tick();
    iss_en = 0;
    #2;
    checks++; if (busy1 !== 1'b1) $display("FAIL busy_cyc1: got %b expected 1", busy1); else passes++;
    tick();
    wr_en = 1; wr_addr = 7; wr_data = 64'h77;
    #2;
    checks++; if (busy1 !== !BYP) $display("FAIL busy_cyc2: got %b expected %b", busy1, !BYP); else passes++;
    tick();
    wr_en = 0;
    #2;
    checks++; if (busy1 !== 1'b0 || rd_data1 !== 64'h77) $display("FAIL busy_cleared: got %b/%h expected 0/77", busy1, rd_data1); else passes++;
    tick();
    wr_en = 1; wr_data = 64'h88; iss_en = 1; iss_addr = 7;
    tick();
    wr_en = 0; iss_en = 0;
    #2;
    checks++; if (busy1 !== 1'b1 || rd_data1 !== 64'h88) $display("FAIL iss_wr_same: got %b/%h expected 1/88", busy1, rd_data1); else passes++;
    tick();
  endtask

  task automatic test_alu_src();
    idle();
    wr_en = 1; wr_addr = 3; wr_data = 64'h55;
    tick();
    idle();
    alu_src = 1; imm = 64'hFF; rd_addr2 = 3;
    #2;
    checks++; if (rd_data2 !== 64'hFF || busy2 !== 1'b0) $display("FAIL alu_imm: got %h/%b expected ff/0", rd_data2, busy2); else passes++;
    iss_en = 1; iss_addr = 3;
    tick();
    iss_en = 0;
    #2;
    checks++; if (rd_data2 !== 64'hFF || busy2 !== 1'b1) $display("FAIL alu_imm_busy: got %h/%b expected ff/1", rd_data2, busy2); else passes++;
    alu_src = 0;
    #1;
    checks++; if (rd_data2 !== 64'h55) $display("FAIL alu_reg: got %h expected 55", rd_data2); else passes++;
    tick();
  endtask

  task automatic test_clear();
    int n;
    idle();
    wr_en = 1; wr_addr = 9; wr_data = 64'hA;
    tick();
    idle();
    clr_req = 1; rd_addr1 = 9;
    #2;
    checks++; if (ready !== 1'b1 || rd_data1 !== 64'hA) $display("FAIL clr_pre: got %b/%h expected 1/a", ready, rd_data1); else passes++;
    tick();
    wr_en = 1; wr_addr = 9; wr_data = 64'hFFFF; iss_en = 1; iss_addr = 9;
    n = 0;
    while (ready === 1'b0 && n < 40) begin
      n++;
      checks++;
      if (rd_data1 !== 64'd0 || busy1 !== 1'b0) $display("FAIL sweep_read c%0d: got %h/%b expected 0/0", n, rd_data1, busy1); else passes++;
      tick();
    end
    idle();
    rd_addr1 = 9;
    checks++; if (n != 32) $display("FAIL clr_cycles: got %0d expected 32", n); else passes++;
    #1;
    checks++; if (rd_data1 !== 64'd0 || busy1 !== 1'b0) $display("FAIL clr_x9: got %h/%b expected 0/0", rd_data1, busy1); else passes++;
    tick();
    clr_req = 1;
    tick();
    clr_req = 0;
    repeat (10) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (ready !== 1'b0) $display("FAIL midsweep_rst_ready: got %b expected 0", ready); else passes++;
    rst_n = 1'b1;
    #1;
    n = 0;
    while (ready === 1'b0 && n < 40) begin n++; tick(); end
    checks++; if (n != 32) $display("FAIL restart_cycles: got %0d expected 32", n); else passes++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      clr_req  = ($urandom_range(0, 79) == 0);
      wr_en    = 1'($urandom);
      wr_addr  = 5'($urandom_range(0, 7));
      wr_data  = {$urandom, $urandom};
      iss_en   = 1'($urandom);
      iss_addr = 5'($urandom_range(0, 7));
      rd_addr1 = 5'($urandom_range(0, 7));
      rd_addr2 = 5'($urandom_range(0, 7));
      alu_src  = ($urandom_range(0, 3) == 0);
      imm      = {$urandom, $urandom};
      #2;
      checks++; if (ready !== m_run) $display("FAIL rnd_ready c%0d: got %b expected %b", c, ready, m_run); else passes++;
      checks++; if (rd_data1 !== exp_rd(rd_addr1, 1'b0)) $display("FAIL rnd_rd1 c%0d: got %h expected %h", c, rd_data1, exp_rd(rd_addr1, 1'b0)); else passes++;
      checks++; if (rd_data2 !== exp_rd(rd_addr2, 1'b1)) $display("FAIL rnd_rd2 c%0d: got %h expected %h", c, rd_data2, exp_rd(rd_addr2, 1'b1)); else passes++;
      checks++; if (busy1 !== exp_busy(rd_addr1)) $display("FAIL rnd_busy1 c%0d: got %b expected %b", c, busy1, exp_busy(rd_addr1)); else passes++;
      checks++; if (busy2 !== exp_busy(rd_addr2)) $display("FAIL rnd_busy2 c%0d: got %b expected %b", c, busy2, exp_busy(rd_addr2)); else passes++;
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_busy();
    test_alu_src();
    test_clear();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
